// File: rtl/wb_pkg.sv
// Shared encodings for the write-back stage: result-source selects and load types.
package wb_pkg;

  // Result source carried with the instruction into WB (3 is reserved and behaves as ALU)
  localparam logic [1:0] WB_SEL_ALU  = 2'd0;
  localparam logic [1:0] WB_SEL_MEM  = 2'd1;
  localparam logic [1:0] WB_SEL_LINK = 2'd2;

  // Load access types (unlisted codes behave as LW)
  localparam logic [2:0] LD_LW  = 3'd0;
  localparam logic [2:0] LD_LB  = 3'd1;
  localparam logic [2:0] LD_LBU = 3'd2;
  localparam logic [2:0] LD_LH  = 3'd3;
  localparam logic [2:0] LD_LHU = 3'd4;

endpackage

// File: rtl/wb_load_ext.sv
// Little-endian byte/half extraction from a raw data-memory word with sign/zero extension.
// Halves ignore addr_lo[0]: misaligned halfword loads are trapped before reaching WB.
module wb_load_ext
  import wb_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [2:0]        ld_type_i,
  input  logic [1:0]        addr_lo_i,
  input  logic [DATA_W-1:0] rdata_i,
  output logic [DATA_W-1:0] ext_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed byte lane and half lane
  always_comb begin
    case (addr_lo_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  // Extend the selected lane according to the load type
  always_comb begin
    case (ld_type_i)
      LD_LB:   ext_o = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
      LD_LBU:  ext_o = {{(DATA_W-8){1'b0}}, byte_sel};
      LD_LH:   ext_o = {{(DATA_W-16){half_sel[15]}}, half_sel};
      LD_LHU:  ext_o = {{(DATA_W-16){1'b0}}, half_sel};
      LD_LW:   ext_o = rdata_i;
      default: ext_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/wb_stage_arb.sv
// Write-back stage: MEM/WB register, result select, and a one-entry aux writer that
// shares the GPR write port. The pipeline always wins the port; a pending aux entry
// drains in the first free slot, and a starvation counter forces a bubble if needed.
module wb_stage_arb
  import wb_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int REG_AW       = 5,
  parameter int STARVE_LIMIT = 8,
  parameter int LINK_OFF     = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              mem_valid,
  input  logic [DATA_W-1:0] mem_pc,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic [1:0]        mem_wb_sel,
  input  logic [2:0]        mem_ld_type,
  input  logic [1:0]        mem_addr_lo,
  input  logic [DATA_W-1:0] mem_result,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              aux_valid,
  output logic              aux_ready,
  input  logic [REG_AW-1:0] aux_rd,
  input  logic [DATA_W-1:0] aux_data,
  output logic              stall_req,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [DATA_W-1:0] wb_pc,
  output logic              wb_valid
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  // WB pipeline register
  logic              wb_valid_q;
  logic [DATA_W-1:0] wb_pc_q, wb_result_q, wb_rdata_q;
  logic [REG_AW-1:0] wb_rd_q;
  logic [1:0]        wb_sel_q, wb_alo_q;
  logic [2:0]        wb_ld_q;

  // Aux buffer and starvation counter
  logic              full_q, full_d;
  logic [REG_AW-1:0] aux_rd_q, aux_rd_d;
  logic [DATA_W-1:0] aux_data_q, aux_data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              pipe_wr;
  logic              drain;
  logic [DATA_W-1:0] ld_ext;
  logic [DATA_W-1:0] pipe_data;

  assign pipe_wr   = wb_valid_q && (wb_rd_q != '0);
  assign drain     = full_q && !pipe_wr;
  assign aux_ready = !full_q;
  assign stall_req = full_q && pipe_wr && (cnt_q >= CNT_W'(STARVE_LIMIT - 1));
  assign wb_valid  = wb_valid_q;
  assign wb_pc     = wb_pc_q;

  wb_load_ext #(.DATA_W(DATA_W)) u_load_ext (
    .ld_type_i (wb_ld_q),
    .addr_lo_i (wb_alo_q),
    .rdata_i   (wb_rdata_q),
    .ext_o     (ld_ext)
  );

  // Capture the MEM stage every edge; reset, flush or our own stall insert a bubble
  always_ff @(posedge clk) begin
    if (reset) begin
      wb_valid_q  <= 1'b0;
      wb_pc_q     <= '0;
      wb_rd_q     <= '0;
      wb_sel_q    <= '0;
      wb_ld_q     <= '0;
      wb_alo_q    <= '0;
      wb_result_q <= '0;
      wb_rdata_q  <= '0;
    end else begin
      wb_valid_q  <= mem_valid && !flush && !stall_req;
      wb_pc_q     <= mem_pc;
      wb_rd_q     <= mem_rd;
      wb_sel_q    <= mem_wb_sel;
      wb_ld_q     <= mem_ld_type;
      wb_alo_q    <= mem_addr_lo;
      wb_result_q <= mem_result;
      wb_rdata_q  <= mem_rdata;
    end
  end

  // Aux next state: drain on a free slot, count blocked cycles, accept only when empty
  always_comb begin
    full_d     = full_q;
    aux_rd_d   = aux_rd_q;
    aux_data_d = aux_data_q;
    cnt_d      = cnt_q;
    if (full_q) begin
      if (drain) begin
        full_d = 1'b0;
        cnt_d  = '0;
      end else if (cnt_q != CNT_W'(STARVE_LIMIT)) begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (aux_valid) begin
      full_d     = 1'b1;
      aux_rd_d   = aux_rd;
      aux_data_d = aux_data;
    end
  end

  // Aux buffer register; flush deliberately leaves it alone
  always_ff @(posedge clk) begin
    if (reset) begin
      full_q     <= 1'b0;
      aux_rd_q   <= '0;
      aux_data_q <= '0;
      cnt_q      <= '0;
    end else begin
      full_q     <= full_d;
      aux_rd_q   <= aux_rd_d;
      aux_data_q <= aux_data_d;
      cnt_q      <= cnt_d;
    end
  end

  // Pipeline result select
  always_comb begin
    case (wb_sel_q)
      WB_SEL_MEM:  pipe_data = ld_ext;
      WB_SEL_LINK: pipe_data = wb_pc_q + DATA_W'(LINK_OFF);
      WB_SEL_ALU:  pipe_data = wb_result_q;
      default:     pipe_data = wb_result_q;
    endcase
  end

  // Write-port mux: pipeline first, then a draining aux entry; idle port drives zeros
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    if (pipe_wr) begin
      rf_we    = 1'b1;
      rf_waddr = wb_rd_q;
      rf_wdata = pipe_data;
    end else if (drain && (aux_rd_q != '0)) begin
      rf_we    = 1'b1;
      rf_waddr = aux_rd_q;
      rf_wdata = aux_data_q;
    end
  end

endmodule

// File: tb/tb_wb_stage_arb.sv
// Bench for wb_stage_arb: directed scenarios plus a randomized run against a
// transaction-level model (WB slot + aux queue + blocked-cycle count).
module tb_wb_stage_arb;
  import wb_pkg::*;

  localparam int LIMIT = 8;

  logic        clk = 1'b0;
  logic        reset, flush, mem_valid, aux_valid;
  logic [31:0] mem_pc, mem_result, mem_rdata, aux_data;
  logic [4:0]  mem_rd, aux_rd;
  logic [1:0]  mem_wb_sel, mem_addr_lo;
  logic [2:0]  mem_ld_type;
  logic        aux_ready, stall_req, rf_we, wb_valid;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata, wb_pc;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  wb_stage_arb #(.DATA_W(32), .REG_AW(5), .STARVE_LIMIT(LIMIT), .LINK_OFF(8)) dut (
    .clk(clk), .reset(reset), .flush(flush), .mem_valid(mem_valid), .mem_pc(mem_pc),
    .mem_rd(mem_rd), .mem_wb_sel(mem_wb_sel), .mem_ld_type(mem_ld_type),
    .mem_addr_lo(mem_addr_lo), .mem_result(mem_result), .mem_rdata(mem_rdata),
    .aux_valid(aux_valid), .aux_ready(aux_ready), .aux_rd(aux_rd), .aux_data(aux_data),
    .stall_req(stall_req), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .wb_pc(wb_pc), .wb_valid(wb_valid)
  );

  // ---------------- reference model ----------------
  typedef struct { logic [4:0] rd; logic [31:0] d; } ent_t;
  ent_t        m_q[$];
  int          m_blk;
  logic        m_valid;
  logic [4:0]  m_rd;
  logic [31:0] m_pc, m_data;

  function automatic logic [31:0] ref_value(logic [1:0] sel, logic [2:0] ld, logic [1:0] a,
                                            logic [31:0] pc, logic [31:0] res, logic [31:0] rd);
    logic [31:0] v;
    if (sel == 2'd2) return pc + 32'd8;
    if (sel != 2'd1) return res;
    case (ld)
      3'd1, 3'd2: begin
        v = (rd >> (8 * a)) & 32'hFF;
        if (ld == 3'd1 && v[7]) v = v | 32'hFFFF_FF00;
      end
      3'd3, 3'd4: begin
        v = (rd >> (a[1] ? 16 : 0)) & 32'hFFFF;
        if (ld == 3'd3 && v[15]) v = v | 32'hFFFF_0000;
      end
      default: v = rd;
    endcase
    return v;
  endfunction

  function automatic logic m_pipe();
    return m_valid && (m_rd != 5'd0);
  endfunction

  function automatic logic m_stall();
    return (m_q.size() != 0) && m_pipe() && (m_blk >= LIMIT - 1);
  endfunction

  // Advance model with the currently driven inputs, then clock the DUT
  task automatic step();
    logic pipe, stall;
    ent_t e;
    pipe  = m_pipe();
    stall = m_stall();
    if (reset) begin
      m_q.delete();
      m_blk = 0; m_valid = 1'b0; m_rd = '0; m_pc = '0; m_data = '0;
    end else begin
      if (m_q.size() != 0) begin
        if (!pipe) begin
          void'(m_q.pop_front());
          m_blk = 0;
        end else if (m_blk < LIMIT) begin
          m_blk++;
        end
      end else if (aux_valid) begin
        e.rd = aux_rd; e.d = aux_data;
        m_q.push_back(e);
      end
      m_valid = mem_valid && !flush && !stall;
      m_rd    = mem_rd;
      m_pc    = mem_pc;
      m_data  = ref_value(mem_wb_sel, mem_ld_type, mem_addr_lo, mem_pc, mem_result, mem_rdata);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reset = 0; flush = 0; mem_valid = 0; aux_valid = 0;
    mem_pc = '0; mem_rd = '0; mem_wb_sel = '0; mem_ld_type = '0; mem_addr_lo = '0;
    mem_result = '0; mem_rdata = '0; aux_rd = '0; aux_data = '0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    idle(); reset = 1;
    step(); step();
    reset = 0;
    n_vec++; if (rf_we !== 1'b0)      begin n_err++; $display("FAIL reset_rf_we got=%0b exp=0", rf_we); end
    n_vec++; if (rf_waddr !== 5'd0)   begin n_err++; $display("FAIL reset_waddr got=%0d exp=0", rf_waddr); end
    n_vec++; if (rf_wdata !== 32'd0)  begin n_err++; $display("FAIL reset_wdata got=%h exp=0", rf_wdata); end
    n_vec++; if (wb_pc !== 32'd0)     begin n_err++; $display("FAIL reset_wb_pc got=%h exp=0", wb_pc); end
    n_vec++; if (wb_valid !== 1'b0)   begin n_err++; $display("FAIL reset_wb_valid got=%0b exp=0", wb_valid); end
    n_vec++; if (stall_req !== 1'b0)  begin n_err++; $display("FAIL reset_stall got=%0b exp=0", stall_req); end
    n_vec++; if (aux_ready !== 1'b1)  begin n_err++; $display("FAIL reset_aux_ready got=%0b exp=1", aux_ready); end
  endtask

  task automatic test_load_ext();
    logic [2:0]  lt  [8] = '{LD_LB, LD_LBU, LD_LHU, LD_LH, LD_LB, LD_LH, LD_LW, 3'd7};
    logic [1:0]  al  [8] = '{2'd3, 2'd3, 2'd2, 2'd2, 2'd0, 2'd0, 2'd1, 2'd2};
    logic [31:0] ex  [8] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_80AB, 32'hFFFF_80AB,
                             32'h0000_0012, 32'hFFFF_CD12, 32'h80AB_CD12, 32'h80AB_CD12};
    for (int i = 0; i < 8; i++) begin
      idle();
      mem_valid = 1; mem_rd = 5'd3; mem_wb_sel = WB_SEL_MEM; mem_ld_type = lt[i];
      mem_addr_lo = al[i]; mem_rdata = 32'h80AB_CD12; mem_result = 32'hDEAD_BEEF;
      step();
      n_vec++;
      if (rf_we !== 1'b1 || rf_waddr !== 5'd3 || rf_wdata !== ex[i]) begin
        n_err++;
        $display("FAIL load_%0d we=%0b waddr=%0d wdata=%h exp we=1 waddr=3 wdata=%h",
                 i, rf_we, rf_waddr, rf_wdata, ex[i]);
      end
    end
    idle(); step();
  endtask

  task automatic test_link();
    idle();
    mem_valid = 1; mem_pc = 32'h0000_3000; mem_rd = 5'd31; mem_wb_sel = WB_SEL_LINK;
    mem_result = 32'h1111_1111;
    step();
    idle();
    n_vec++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd31 || rf_wdata !== 32'h0000_3008 ||
        wb_pc !== 32'h0000_3000 || wb_valid !== 1'b1) begin
      n_err++;
      $display("FAIL link we=%0b waddr=%0d wdata=%h pc=%h v=%0b exp 1/31/00003008/00003000/1",
               rf_we, rf_waddr, rf_wdata, wb_pc, wb_valid);
    end
    step();
  endtask

  task automatic test_aux_basic();
    idle(); step();
    aux_valid = 1; aux_rd = 5'd5; aux_data = 32'h0000_1234;
    step();
    aux_valid = 0;
    n_vec++;
    if (aux_ready !== 1'b0 || rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'h1234) begin
      n_err++;
      $display("FAIL aux_drain ready=%0b we=%0b waddr=%0d wdata=%h exp 0/1/5/00001234",
               aux_ready, rf_we, rf_waddr, rf_wdata);
    end
    step();
    n_vec++;
    if (aux_ready !== 1'b1 || rf_we !== 1'b0) begin
      n_err++;
      $display("FAIL aux_after ready=%0b we=%0b exp 1/0", aux_ready, rf_we);
    end
  endtask

  task automatic test_starve();
    idle();
    mem_valid = 1; mem_rd = 5'd7; mem_wb_sel = WB_SEL_ALU; mem_result = 32'h0000_0777;
    aux_valid = 1; aux_rd = 5'd9; aux_data = 32'h0000_9999;
    step();
    aux_valid = 0;
    for (int k = 1; k <= LIMIT; k++) begin
      n_vec++;
      if (stall_req !== (k == LIMIT) || rf_we !== 1'b1 || rf_waddr !== 5'd7 || aux_ready !== 1'b0) begin
        n_err++;
        $display("FAIL starve_blk%0d stall=%0b we=%0b waddr=%0d ready=%0b exp stall=%0b we=1 waddr=7 ready=0",
                 k, stall_req, rf_we, rf_waddr, aux_ready, (k == LIMIT));
      end
      step();
    end
    n_vec++;
    if (stall_req !== 1'b0 || rf_we !== 1'b1 || rf_waddr !== 5'd9 || rf_wdata !== 32'h9999 || wb_valid !== 1'b0) begin
      n_err++;
      $display("FAIL starve_drain stall=%0b we=%0b waddr=%0d wdata=%h v=%0b exp 0/1/9/00009999/0",
               stall_req, rf_we, rf_waddr, rf_wdata, wb_valid);
    end
    step();
    n_vec++;
    if (aux_ready !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'h777) begin
      n_err++;
      $display("FAIL starve_resume ready=%0b waddr=%0d wdata=%h exp 1/7/00000777", aux_ready, rf_waddr, rf_wdata);
    end
    idle(); step();
  endtask

  task automatic test_zero_rd();
    idle();
    mem_valid = 1; mem_rd = 5'd0; mem_result = 32'hAAAA_AAAA;
    aux_valid = 1; aux_rd = 5'd0; aux_data = 32'h0000_0055;
    step();
    idle();
    n_vec++;
    if (rf_we !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 32'd0 || aux_ready !== 1'b0 || wb_valid !== 1'b1) begin
      n_err++;
      $display("FAIL zero_rd we=%0b waddr=%0d wdata=%h ready=%0b v=%0b exp 0/0/0/0/1",
               rf_we, rf_waddr, rf_wdata, aux_ready, wb_valid);
    end
    step();
    n_vec++;
    if (rf_we !== 1'b0 || aux_ready !== 1'b1) begin
      n_err++;
      $display("FAIL zero_rd_after we=%0b ready=%0b exp 0/1", rf_we, aux_ready);
    end
  endtask

  task automatic test_flush();
    idle();
    mem_valid = 1; mem_rd = 5'd4; mem_result = 32'h4444_4444; flush = 1;
    step();
    idle();
    n_vec++;
    if (wb_valid !== 1'b0 || rf_we !== 1'b0) begin
      n_err++;
      $display("FAIL flush v=%0b we=%0b exp 0/0", wb_valid, rf_we);
    end
  endtask

  task automatic test_reset_midop();
    idle();
    mem_valid = 1; mem_rd = 5'd6; mem_result = 32'h6666_6666;
    aux_valid = 1; aux_rd = 5'd10; aux_data = 32'h0000_0A0A;
    step();
    n_vec++;
    if (aux_ready !== 1'b0) begin n_err++; $display("FAIL midop_full ready=%0b exp 0", aux_ready); end
    idle(); reset = 1;
    step();
    reset = 0;
    n_vec++;
    if (aux_ready !== 1'b1 || rf_we !== 1'b0) begin
      n_err++;
      $display("FAIL midop_reset ready=%0b we=%0b exp 1/0", aux_ready, rf_we);
    end
    step();
    n_vec++;
    if (rf_we !== 1'b0 || aux_ready !== 1'b1) begin
      n_err++;
      $display("FAIL midop_discard we=%0b waddr=%0d ready=%0b exp 0/-/1", rf_we, rf_waddr, aux_ready);
    end
  endtask

  task automatic test_random(int cycles, int busy);
    logic        e_we;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    for (int c = 0; c < cycles; c++) begin
      e_we = 1'b0; e_addr = '0; e_data = '0;
      if (m_pipe()) begin
        e_we = 1'b1; e_addr = m_rd; e_data = m_data;
      end else if (m_q.size() != 0 && m_q[0].rd != 5'd0) begin
        e_we = 1'b1; e_addr = m_q[0].rd; e_data = m_q[0].d;
      end
      n_vec++;
      if (rf_we !== e_we || rf_waddr !== e_addr || rf_wdata !== e_data || wb_valid !== m_valid ||
          stall_req !== m_stall() || aux_ready !== (m_q.size() == 0) || (m_valid && wb_pc !== m_pc)) begin
        n_err++;
        $display("FAIL rand_%0d we=%0b waddr=%0d wdata=%h v=%0b stall=%0b ready=%0b pc=%h exp we=%0b waddr=%0d wdata=%h v=%0b stall=%0b ready=%0b pc=%h",
                 c, rf_we, rf_waddr, rf_wdata, wb_valid, stall_req, aux_ready, wb_pc,
                 e_we, e_addr, e_data, m_valid, m_stall(), (m_q.size() == 0), m_pc);
      end
      reset       = ($urandom_range(0, 99) == 0);
      flush       = ($urandom_range(0, 9) == 0);
      mem_valid   = ($urandom_range(0, 99) < busy);
      mem_pc      = $urandom & 32'hFFFF_FFFC;
      mem_rd      = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      mem_wb_sel  = 2'($urandom_range(0, 3));
      mem_ld_type = 3'($urandom_range(0, 7));
      mem_addr_lo = 2'($urandom_range(0, 3));
      mem_result  = $urandom;
      mem_rdata   = $urandom;
      aux_valid   = ($urandom_range(0, 2) == 0);
      aux_rd      = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      aux_data    = $urandom;
      step();
    end
    idle();
  endtask

  initial begin
    idle();
    m_q.delete(); m_blk = 0; m_valid = 0; m_rd = '0; m_pc = '0; m_data = '0;
    test_reset();
    test_load_ext();
    test_link();
    test_aux_basic();
    test_starve();
    test_zero_rd();
    test_flush();
    test_reset_midop();
    test_random(1500, 75);
    test_random(1500, 97);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
